// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divider: start pulse, bounded wait, HI/LO commit, status pulse.
// Optional completed-operation counter enabled by defining MULDIV_STATS_EN.
module muldiv_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_mult,
    input  logic        req_div,
    input  logic        mult_ready,
    input  logic        div_ready,
    input  logic        div_zero,
    output logic        mult_start,
    output logic        div_start,
    output logic        hi_wr,
    output logic        lo_wr,
    output logic        hilo_sel,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic        timeout_err,
    output logic [15:0] op_count
);

    typedef enum logic [3:0] {
        IDLE, START_M, WAIT_M, START_D, WAIT_D, WRITE, DONE, EXC, TMO
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Outputs are registered alongside the state they belong to, so each one
    // is a pure function of the current state with no input-to-output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            hilo_sel     <= 1'b0;
            mult_start   <= 1'b0;
            div_start    <= 1'b0;
            hi_wr        <= 1'b0;
            lo_wr        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            mult_start   <= 1'b0;
            div_start    <= 1'b0;
            hi_wr        <= 1'b0;
            lo_wr        <= 1'b0;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_mult) begin
                        state      <= START_M;
                        hilo_sel   <= 1'b0;
                        mult_start <= 1'b1;
                        busy       <= 1'b1;
                    end else if (req_div) begin
                        state     <= START_D;
                        hilo_sel  <= 1'b1;
                        div_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                // Ready lines are not looked at here: they may still be stale.
                START_M: begin
                    state <= WAIT_M;
                    cnt   <= '0;
                end
                START_D: begin
                    state <= WAIT_D;
                    cnt   <= '0;
                end
                WAIT_M: begin
                    if (mult_ready) begin
                        state <= WRITE;
                        hi_wr <= 1'b1;
                        lo_wr <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state       <= TMO;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_D: begin
                    if (div_zero) begin
                        state        <= EXC;
                        div_zero_exc <= 1'b1;
                    end else if (div_ready) begin
                        state <= WRITE;
                        hi_wr <= 1'b1;
                        lo_wr <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state       <= TMO;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE, EXC, TMO: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MULDIV_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= 16'h0000;
        end else if (state == DONE && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'h0001;
        end
    end
`else
    assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, reset-abort sequence,
// and randomized operations scored against a transaction-level schedule model.
module tb_muldiv_sequencer;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_mult = 1'b0, req_div = 1'b0;
    logic        mult_ready = 1'b0, div_ready = 1'b0, div_zero = 1'b0;
    logic        mult_start, div_start, hi_wr, lo_wr, hilo_sel, busy;
    logic        done, div_zero_exc, timeout_err;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;
    int exp_ops = 0;

    muldiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .req_mult(req_mult), .req_div(req_div),
        .mult_ready(mult_ready), .div_ready(div_ready), .div_zero(div_zero),
        .mult_start(mult_start), .div_start(div_start),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .hilo_sel(hilo_sel), .busy(busy),
        .done(done), .div_zero_exc(div_zero_exc), .timeout_err(timeout_err),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // kind: 0 = committed (done), 1 = divide-by-zero, 2 = timeout
    typedef struct {
        bit m;
        bit d;
        int rdy;
        int zero;
        bit stale;
        int kind;
        int e;
    } vec_t;

    task automatic check(input string name, input int t, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {mult_start, div_start, hi_wr, lo_wr, done, div_zero_exc, timeout_err, busy};
    endfunction

    // Event index = earliest WAIT cycle in which something ends the wait;
    // zero-divisor beats ready beats timeout when they coincide.
    task automatic model(input bit m, input int rdy, input int zero, output int kind, output int e);
        e = TIMEOUT - 1;
        kind = 2;
        if (rdy >= 0 && rdy <= e) begin e = rdy; kind = 0; end
        if (!m && zero >= 0 && zero <= e) begin e = zero; kind = 1; end
    endtask

    // Called just after a rising edge with the DUT idle. t=0 is the request cycle.
    task automatic run_op(input bit m, input bit d, input int rdy, input int zero,
                          input bit stale, input bit noise, input int kind, input int e);
        int          end_t;
        bit          sel_rdy, zro;
        logic [7:0]  exp;
        end_t = (kind == 0) ? 4 + e : 3 + e;
        for (int t = 0; t <= end_t + 1; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            exp = {(t == 1) && m, (t == 1) && !m,
                   (kind == 0) && (t == 3 + e), (kind == 0) && (t == 3 + e),
                   (kind == 0) && (t == 4 + e),
                   (kind == 1) && (t == 3 + e),
                   (kind == 2) && (t == 3 + e),
                   (t >= 1) && (t <= end_t)};
            check("outputs", t, {24'h0, outs()}, {24'h0, exp});
            if (t >= 1 && t <= end_t) check("hilo_sel", t, {31'h0, hilo_sel}, {31'h0, !m});
            if (t == end_t + 1) begin
`ifdef MULDIV_STATS_EN
                if (kind == 0) exp_ops++;
`endif
                check("op_count", t, {16'h0, op_count}, exp_ops);
            end
            sel_rdy = (t == 1 && stale) || (rdy >= 0 && t >= 2 + rdy && t <= end_t);
            zro = zero >= 0 && t >= 2 + zero && t <= end_t;
            if (t == 0) begin
                req_mult = m;
                req_div  = d;
            end else if (noise && t <= end_t) begin
                req_mult = 1'($urandom_range(0, 1));
                req_div  = 1'($urandom_range(0, 1));
            end else begin
                req_mult = 1'b0;
                req_div  = 1'b0;
            end
            if (t > end_t) begin
                mult_ready = 1'b0; div_ready = 1'b0; div_zero = 1'b0;
            end else if (m) begin
                mult_ready = sel_rdy;
                div_ready  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                div_zero   = zro || (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            end else begin
                div_ready  = sel_rdy;
                div_zero   = zro;
                mult_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 1'b0,  6, -1, 1'b0, 0,  6};
        tbl[1]  = '{1'b0, 1'b1,  3, -1, 1'b0, 0,  3};
        tbl[2]  = '{1'b0, 1'b1, -1,  0, 1'b0, 1,  0};
        tbl[3]  = '{1'b1, 1'b0, -1, -1, 1'b0, 2, 39};
        tbl[4]  = '{1'b1, 1'b1,  2, -1, 1'b0, 0,  2};
        tbl[5]  = '{1'b1, 1'b0,  5, -1, 1'b1, 0,  5};
        tbl[6]  = '{1'b0, 1'b1,  2,  2, 1'b0, 1,  2};
        tbl[7]  = '{1'b0, 1'b1, 39, -1, 1'b0, 0, 39};
        tbl[8]  = '{1'b0, 1'b1, -1, -1, 1'b1, 2, 39};
        tbl[9]  = '{1'b0, 1'b1, 10,  5, 1'b0, 1,  5};
        tbl[10] = '{1'b1, 1'b0,  1,  0, 1'b0, 0,  1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 0, {24'h0, outs()}, 32'h0);
        check("reset_hilo_sel", 0, {31'h0, hilo_sel}, 32'h0);
        check("reset_op_count", 0, {16'h0, op_count}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++)
            run_op(tbl[i].m, tbl[i].d, tbl[i].rdy, tbl[i].zero, tbl[i].stale, 1'b0, tbl[i].kind, tbl[i].e);

        // Busy-time requests and stray ready/zero lines on the idle unit.
        run_op(1'b0, 1'b1, 7, -1, 1'b1, 1'b1, 0, 7);
        run_op(1'b1, 1'b0, 4, -1, 1'b0, 1'b1, 0, 4);

        // Reset in the WAIT_D cycle that sees div_ready aborts without a commit.
        req_div = 1'b1;
        @(posedge clk); #1;
        req_div = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        div_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        div_ready = 1'b0;
        exp_ops = 0;
        check("abort_outputs", 0, {24'h0, outs()}, 32'h0);
        check("abort_hilo_sel", 0, {31'h0, hilo_sel}, 32'h0);
        check("abort_op_count", 0, {16'h0, op_count}, 32'h0);
        @(posedge clk); #1;
        check("abort_after", 1, {24'h0, outs()}, 32'h0);
        run_op(1'b1, 1'b0, 0, -1, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 100; i++) begin
            bit m, d, stale, noise;
            int rdy, zero, kind, e, r;
            m = 1'($urandom_range(0, 1));
            d = m ? 1'($urandom_range(0, 1)) : 1'b1;
            r = int'($urandom_range(0, 9));
            rdy = (r < 2) ? -1 : int'($urandom_range(0, 45));
            r = int'($urandom_range(0, 9));
            zero = (r < 6) ? -1 : int'($urandom_range(0, 45));
            stale = 1'($urandom_range(0, 1));
            noise = 1'($urandom_range(0, 1));
            model(m, rdy, zero, kind, e);
            run_op(m, d, rdy, zero, stale, noise, kind, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
